pulse_period_meter: RTL
=======================

Name: pulse_period_meter

Overview:
Receive-side companion to the team's enable-pulse prescaler. It watches a single-cycle enable-pulse train and recovers the prescale value that produced it, so periodValue equals the prescaler's preScaleValue setting. It declares lock after a programmable number of consecutive identical periods and flags loss of pulses (overflow). It is used in the prefetcher's rate-control and debug paths, and in self-checking benches, to confirm the slow-enable rate.

Parameters:
WIDTH, 10, width of the period counter and periodValue; max measurable period is 2^WIDTH-1.
LOCK_COUNT, 4, number of consecutive identical measurements required to assert locked; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge.
resetN  input  1  reset, asynchronous, active-low.
pulseIn  input  1  enable pulse; every cycle sampled high is one pulse event (level, not edge; constant high = pulse every cycle).
clearReq  input  1  synchronous clear, active-high, one cycle.
periodValue  output  WIDTH  last measured period = number of non-pulse cycles between consecutive pulses.
periodValid  output  1  one-cycle strobe, high the cycle after each measurement.
locked  output  1  LOCK_COUNT consecutive identical measurements seen.
overflow  output  1  sticky; no pulse for 2^WIDTH consecutive cycles while armed.

Behaviour:
- Reset (async, resetN=0): state=IDLE; cnt=0; matchCnt=0; periodValue=0; periodValid=0; locked=0; overflow=0. All outputs are registered and clear immediately on reset.
- States: IDLE (no reference pulse), ACQUIRE (counting, not locked), LOCKED.
- Counter cnt (WIDTH bits):
  - Loads 0 on every pulse cycle.
  - Increments on each non-pulse cycle in ACQUIRE/LOCKED.
  - Held at 0 in IDLE.
  - At a pulse, cnt equals the count of non-pulse cycles since the previous pulse.
- IDLE:
  - pulseIn=1 -> ACQUIRE, cnt<=0, matchCnt<=0.
  - No measurement and no periodValid for this first pulse.
- ACQUIRE/LOCKED, pulseIn=1 (measurement m=cnt):
  - periodValue<=m and periodValid<=1 next cycle; one cycle of latency.
  - If matchCnt==0 or m!=periodValue: matchCnt<=1.
  - Otherwise matchCnt<=min(matchCnt+1, LOCK_COUNT).
  - Transition to LOCKED and locked<=1 when the new matchCnt==LOCK_COUNT. With LOCK_COUNT=1, this happens on the first measurement.
  - In LOCKED, m!=periodValue -> ACQUIRE, locked<=0, matchCnt<=1; the same cycle's periodValid still reports m.
- ACQUIRE/LOCKED, pulseIn=0:
  - If cnt==2^WIDTH-1 -> overflow<=1, locked<=0, matchCnt<=0, state<=IDLE. periodValue is held.
  - Otherwise cnt<=cnt+1.
  - Consequently, overflow asserts after exactly 2^WIDTH consecutive quiet cycles.
  - A pulse arriving with cnt=2^WIDTH-1 is a valid measurement.
- overflow:
  - Sticky; cleared only by clearReq or reset.
  - Measurement resumes normally after an overflow: the next pulse re-arms from IDLE without itself measuring.
- clearReq=1 has priority over pulseIn in the same cycle:
  - Next cycle, all state and outputs are at reset values.
  - A coincident pulse is discarded, so the next pulse is treated as the first.
- periodValid is never high for two measurements without an intervening pulse. With constant pulseIn=1, periodValid is high every cycle from the cycle after the 2nd pulse, with periodValue=0.
- Simultaneous lock and mismatch cannot occur; mismatch always resets matchCnt to 1.

Test Plan:
- Pulses every 6 cycles (prescaler preScale=5), LOCK_COUNT=4 -> periodValid first the cycle after the 2nd pulse with periodValue=5; locked rises the cycle after the 5th pulse; overflow=0.
- pulseIn held high from cycle 10 -> periodValue=0, periodValid from cycle 12 every cycle, locked rises at cycle 15.
- Locked at 5, then pulses every 10 cycles -> cycle after first 9-measurement: periodValue=9, locked=0; locked re-asserts after the 4th consecutive 9-measurement.
- WIDTH=10, armed, pulseIn low 1023 cycles then pulse -> periodValue=1023, no overflow. Repeat with 1024 quiet cycles -> overflow=1, locked=0; the next pulse gives no periodValid, and the pulse after that measures normally.
- clearReq coincident with a pulse while locked -> next cycle all outputs 0; following pulse produces no periodValid; second following pulse measures.
- resetN driven low mid-period while locked (asynchronous, between clock edges) -> locked/periodValue/periodValid/overflow go to 0 without a clock edge; after release, behaviour matches a fresh start.

Source files
------------

// File: rtl/pulse_period_meter.sv
// Pulse period meter: recovers the prescale value behind a single-cycle
// enable-pulse train, declares lock after LOCK_COUNT identical periods and
// flags a sticky overflow when pulses stop arriving.
//
// Ports:
//   clk          system clock, rising edge
//   resetN       asynchronous active-low reset
//   pulseIn      enable pulse, sampled as a level every cycle
//   clearReq     synchronous clear, wins over a coincident pulse
//   periodValue  last measured period (non-pulse cycles between pulses)
//   periodValid  one-cycle strobe the cycle after each measurement
//   locked       LOCK_COUNT consecutive identical measurements seen
//   overflow     sticky: 2^WIDTH consecutive quiet cycles while armed
module pulse_period_meter #(
    parameter int unsigned WIDTH      = 10,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             pulseIn,
    input  logic             clearReq,
    output logic [WIDTH-1:0] periodValue,
    output logic             periodValid,
    output logic             locked,
    output logic             overflow
);

    localparam int unsigned MATCH_W = 4;
    localparam logic [MATCH_W-1:0] LOCK_C  = MATCH_W'(LOCK_COUNT);
    localparam logic [WIDTH-1:0]   CNT_MAX = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WIDTH-1:0]   period_value_q, period_value_d;
    logic               period_valid_q, period_valid_d;
    logic               locked_q, locked_d;
    logic               overflow_q, overflow_d;

    // State register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            match_q        <= '0;
            period_value_q <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            match_q        <= match_d;
            period_value_q <= period_value_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            overflow_q     <= overflow_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        match_d        = match_q;
        period_value_d = period_value_q;
        period_valid_d = 1'b0;
        locked_d       = locked_q;
        overflow_d     = overflow_q;

        if (clearReq) begin
            // Coincident pulse is dropped; the next pulse is a fresh reference
            state_d        = IDLE;
            cnt_d          = '0;
            match_d        = '0;
            period_value_d = '0;
            locked_d       = 1'b0;
            overflow_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (pulseIn) begin
                        state_d = ACQUIRE;
                        match_d = '0;
                    end
                end
                ACQUIRE, LOCKED: begin
                    if (pulseIn) begin
                        period_value_d = cnt_q;
                        period_valid_d = 1'b1;
                        cnt_d          = '0;
                        if (match_q == '0 || cnt_q != period_value_q) begin
                            match_d = MATCH_W'(1);
                        end else if (match_q >= LOCK_C) begin
                            match_d = LOCK_C;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                        if (match_d == LOCK_C) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end else begin
                            state_d  = ACQUIRE;
                            locked_d = 1'b0;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        // 2^WIDTH quiet cycles: disarm, keep the last period
                        state_d    = IDLE;
                        cnt_d      = '0;
                        match_d    = '0;
                        locked_d   = 1'b0;
                        overflow_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    match_d = '0;
                end
            endcase
        end
    end

    assign periodValue = period_value_q;
    assign periodValid = period_valid_q;
    assign locked      = locked_q;
    assign overflow    = overflow_q;

endmodule
